// File: rtl/fabric_common.sv
// Shared fabric error package: error codes used across fabric blocks and a
// helper that locates the fields of a tag-map CAM entry.
// Entry layout, LSB first: {dst_tag, mask, src_tag, valid}.
package fabric_common;

    localparam int unsigned ERR_CODE_WIDTH = 16;

    typedef logic [ERR_CODE_WIDTH-1:0] err_code_t;

    localparam err_code_t CFG_MAP_TAG_DUP_TAG  = 16'h0103;
    localparam err_code_t CFG_MAP_TAG_BAD_ADDR = 16'h0104;
    localparam err_code_t RT_MAP_TAG_NO_MATCH  = 16'h0201;

    typedef enum logic [1:0] {
        MAP_FIELD_VALID,
        MAP_FIELD_SRC,
        MAP_FIELD_MASK,
        MAP_FIELD_DST
    } map_field_e;

    // Bit offset of a field inside a tag-map entry for a given input tag width.
    function automatic int unsigned map_entry_offset(map_field_e field, int unsigned in_tag_w);
        case (field)
            MAP_FIELD_VALID: return 0;
            MAP_FIELD_SRC:   return 1;
            MAP_FIELD_MASK:  return 1 + in_tag_w;
            default:         return 1 + 2 * in_tag_w;
        endcase
    endfunction

endpackage

// File: rtl/fabric_map_tag_pipe_pkg.sv
// Local constants and helpers for fabric_map_tag_pipe.
package fabric_map_tag_pipe_pkg;

    localparam int unsigned STAT_WIDTH = 32;

    // Table index width: at least one bit even for a single-entry table.
    function automatic int unsigned map_addr_width(int unsigned table_size);
        return (table_size <= 1) ? 1 : $clog2(table_size);
    endfunction

endpackage

// File: rtl/fabric_map_tag_pipe_if.sv
// Stream and configuration bundle for fabric_map_tag_pipe.
// master: token source / table writer / token sink side.
// slave : the tag map block.
//   in_valid/in_ready/in_data    input stream, in_data = {tag, value}
//   out_valid/out_ready/out_data output stream, out_data = {dst_tag, value}
//   cfg_we/cfg_addr/cfg_wdata    table write port
interface fabric_map_tag_pipe_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned IN_TAG_WIDTH  = 4,
    parameter int unsigned OUT_TAG_WIDTH = 2,
    parameter int unsigned TABLE_SIZE    = 8
);
    import fabric_map_tag_pipe_pkg::*;

    localparam int unsigned ADDR_WIDTH  = map_addr_width(TABLE_SIZE);
    localparam int unsigned ENTRY_WIDTH = 1 + 2 * IN_TAG_WIDTH + OUT_TAG_WIDTH;

    logic                                  in_valid;
    logic                                  in_ready;
    logic [DATA_WIDTH+IN_TAG_WIDTH-1:0]    in_data;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [DATA_WIDTH+OUT_TAG_WIDTH-1:0]   out_data;
    logic                                  cfg_we;
    logic [ADDR_WIDTH-1:0]                 cfg_addr;
    logic [ENTRY_WIDTH-1:0]                cfg_wdata;

    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/fabric_skid_fifo2.sv
// Generic 2-entry valid/ready buffer with registered in_ready/out_valid.
// in_ready depends only on the stored count, never on out_ready, so a pop at
// full frees the slot for the following cycle.
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready/in_data    push side
//   out_valid/out_ready/out_data pop side, out_data = head
module fabric_skid_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "fabric_skid_fifo2: WIDTH must be >= 1");
    end

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             push, pop;

    // Next-state: head is always the output slot, tail only used at count 2.
    always_comb begin : p_next
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        push    = in_valid && ready_q;
        pop     = valid_q && out_ready;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = in_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    tail_d  = in_data;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
        endcase
        ready_d = (count_d != 2'd2);
        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = head_q;

endmodule

// File: rtl/fabric_map_tag_pipe.sv
// Pipelined runtime-writable tag translator: each accepted token's tag is
// looked up in a masked CAM (lowest matching index wins) and forwarded as
// {dst_tag, value} through a 2-entry buffer; misses are dropped.
// Optional macro FABRIC_MAP_TAG_PIPE_STATS_EN adds saturating hit/miss counters.
//   clk, rst         clock, async active-high reset
//   bus (slave)      input/output streams and table write port
//   error_valid      sticky error flag
//   error_code       first error code seen since reset
//   hit_count, miss_count  accepted hit/miss counts (stats build only)
module fabric_map_tag_pipe
    import fabric_common::*;
    import fabric_map_tag_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned IN_TAG_WIDTH  = 4,
    parameter int unsigned OUT_TAG_WIDTH = 2,
    parameter int unsigned TABLE_SIZE    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    fabric_map_tag_pipe_if.slave      bus,
    output logic                      error_valid,
    output logic [ERR_CODE_WIDTH-1:0] error_code
`ifdef FABRIC_MAP_TAG_PIPE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]     hit_count,
    output logic [STAT_WIDTH-1:0]     miss_count
`endif
);

    localparam int unsigned ADDR_WIDTH  = map_addr_width(TABLE_SIZE);
    localparam int unsigned ENTRY_WIDTH = 1 + 2 * IN_TAG_WIDTH + OUT_TAG_WIDTH;
    localparam int unsigned VALID_OFF   = map_entry_offset(MAP_FIELD_VALID, IN_TAG_WIDTH);
    localparam int unsigned SRC_OFF     = map_entry_offset(MAP_FIELD_SRC, IN_TAG_WIDTH);
    localparam int unsigned MASK_OFF    = map_entry_offset(MAP_FIELD_MASK, IN_TAG_WIDTH);
    localparam int unsigned DST_OFF     = map_entry_offset(MAP_FIELD_DST, IN_TAG_WIDTH);
    localparam int unsigned OUT_W       = DATA_WIDTH + OUT_TAG_WIDTH;

    if (DATA_WIDTH < 1) begin : g_bad_data
        $fatal(1, "fabric_map_tag_pipe: DATA_WIDTH must be >= 1");
    end
    if (IN_TAG_WIDTH < 1) begin : g_bad_in_tag
        $fatal(1, "fabric_map_tag_pipe: IN_TAG_WIDTH must be >= 1");
    end
    if (OUT_TAG_WIDTH < 1) begin : g_bad_out_tag
        $fatal(1, "fabric_map_tag_pipe: OUT_TAG_WIDTH must be >= 1");
    end
    if (TABLE_SIZE < 1) begin : g_bad_table
        $fatal(1, "fabric_map_tag_pipe: TABLE_SIZE must be >= 1");
    end

    logic [ENTRY_WIDTH-1:0]    table_q [TABLE_SIZE];
    logic [ENTRY_WIDTH-1:0]    table_d [TABLE_SIZE];
    logic                      addr_in_range;
    logic                      bad_addr;
    logic [IN_TAG_WIDTH-1:0]   in_tag;
    logic                      hit;
    logic [OUT_TAG_WIDTH-1:0]  dst_tag;
    logic                      dup;
    logic                      accept;
    logic                      buf_ready;
    logic                      buf_valid;
    logic [OUT_W-1:0]          buf_data;
    logic                      error_valid_q, error_valid_d;
    logic [ERR_CODE_WIDTH-1:0] error_code_q, error_code_d;

    assign in_tag = bus.in_data[DATA_WIDTH +: IN_TAG_WIDTH];
    assign accept = bus.in_valid && buf_ready;

    // Table write; an address with no matching entry is flagged, not written.
    always_comb begin : p_cfg
        table_d       = table_q;
        addr_in_range = 1'b0;
        for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
            if (bus.cfg_addr == ADDR_WIDTH'(i)) begin
                addr_in_range = 1'b1;
                if (bus.cfg_we) begin
                    table_d[i] = bus.cfg_wdata;
                end
            end
        end
        bad_addr = bus.cfg_we && !addr_in_range;
    end

    // Masked match on the registered table; scanning downward lets the lowest index win.
    always_comb begin : p_lookup
        hit     = 1'b0;
        dst_tag = '0;
        for (int i = int'(TABLE_SIZE) - 1; i >= 0; i--) begin
            if (table_q[i][VALID_OFF] &&
                (((in_tag ^ table_q[i][SRC_OFF +: IN_TAG_WIDTH]) &
                  table_q[i][MASK_OFF +: IN_TAG_WIDTH]) == '0)) begin
                hit     = 1'b1;
                dst_tag = table_q[i][DST_OFF +: OUT_TAG_WIDTH];
            end
        end
    end

    // Two valid entries with identical {mask, src_tag} (adjacent fields, compared together).
    always_comb begin : p_dup
        dup = 1'b0;
        for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
            for (int unsigned j = i + 1; j < TABLE_SIZE; j++) begin
                if (table_q[i][VALID_OFF] && table_q[j][VALID_OFF] &&
                    (table_q[i][SRC_OFF +: 2*IN_TAG_WIDTH] ==
                     table_q[j][SRC_OFF +: 2*IN_TAG_WIDTH])) begin
                    dup = 1'b1;
                end
            end
        end
    end

    // First-error latch with fixed same-cycle priority.
    always_comb begin : p_error
        error_valid_d = error_valid_q;
        error_code_d  = error_code_q;
        if (!error_valid_q) begin
            if (dup) begin
                error_valid_d = 1'b1;
                error_code_d  = CFG_MAP_TAG_DUP_TAG;
            end else if (bad_addr) begin
                error_valid_d = 1'b1;
                error_code_d  = CFG_MAP_TAG_BAD_ADDR;
            end else if (accept && !hit) begin
                error_valid_d = 1'b1;
                error_code_d  = RT_MAP_TAG_NO_MATCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
                table_q[i] <= '0;
            end
            error_valid_q <= 1'b0;
            error_code_q  <= '0;
        end else begin
            table_q       <= table_d;
            error_valid_q <= error_valid_d;
            error_code_q  <= error_code_d;
        end
    end

    // Misses are accepted alongside hits but never pushed.
    fabric_skid_fifo2 #(
        .WIDTH(OUT_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid && hit),
        .in_ready (buf_ready),
        .in_data  ({dst_tag, bus.in_data[DATA_WIDTH-1:0]}),
        .out_valid(buf_valid),
        .out_ready(bus.out_ready),
        .out_data (buf_data)
    );

    assign bus.in_ready  = buf_ready;
    assign bus.out_valid = buf_valid;
    assign bus.out_data  = buf_data;
    assign error_valid   = error_valid_q;
    assign error_code    = error_code_q;

`ifdef FABRIC_MAP_TAG_PIPE_STATS_EN
    logic [STAT_WIDTH-1:0] hit_count_q, hit_count_d;
    logic [STAT_WIDTH-1:0] miss_count_q, miss_count_d;

    // Saturating accepted-token counters.
    always_comb begin : p_stats
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (accept && hit && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + STAT_WIDTH'(1);
        end
        if (accept && !hit && (miss_count_q != '1)) begin
            miss_count_d = miss_count_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_stats_regs
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_fabric_map_tag_pipe.sv
// Self-checking bench for fabric_map_tag_pipe: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// queue-based behavioural model.
module tb_fabric_map_tag_pipe;
    import fabric_common::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned ITW = 4;
    localparam int unsigned OTW = 2;
    localparam int unsigned TS  = 6;
    localparam int unsigned AW  = 3;
    localparam int unsigned EW  = 1 + 2 * ITW + OTW;

    logic        clk = 1'b0;
    logic        rst;
    logic        error_valid;
    logic [15:0] error_code;
`ifdef FABRIC_MAP_TAG_PIPE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    fabric_map_tag_pipe_if #(
        .DATA_WIDTH(DW), .IN_TAG_WIDTH(ITW), .OUT_TAG_WIDTH(OTW), .TABLE_SIZE(TS)
    ) bus ();

    fabric_map_tag_pipe #(
        .DATA_WIDTH(DW), .IN_TAG_WIDTH(ITW), .OUT_TAG_WIDTH(OTW), .TABLE_SIZE(TS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .error_valid(error_valid),
        .error_code (error_code)
`ifdef FABRIC_MAP_TAG_PIPE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state
    logic [DW+OTW-1:0] mq[$];
    logic              m_v    [TS];
    logic [ITW-1:0]    m_src  [TS];
    logic [ITW-1:0]    m_mask [TS];
    logic [OTW-1:0]    m_dst  [TS];
    logic              m_err_v;
    logic [15:0]       m_err_code;
    longint unsigned   m_hits;
    longint unsigned   m_miss;

    function automatic logic [EW-1:0] mk(input logic [OTW-1:0] dst, input logic [ITW-1:0] mask,
                                         input logic [ITW-1:0] src, input logic v);
        return {dst, mask, src, v};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < TS; i++) begin
            m_v[i] = 1'b0; m_src[i] = '0; m_mask[i] = '0; m_dst[i] = '0;
        end
        m_err_v = 1'b0; m_err_code = '0; m_hits = 0; m_miss = 0;
    endtask

    // One clock edge of the spec's rules, using pre-edge inputs and table.
    task automatic model_step();
        int              cnt;
        logic            acc, pop, hit, dup, bad;
        logic [ITW-1:0]  tag;
        logic [OTW-1:0]  dst;
        int              a;
        cnt = mq.size();
        acc = bus.in_valid && (cnt != 2);
        pop = (cnt != 0) && bus.out_ready;
        tag = bus.in_data[DW +: ITW];
        hit = 1'b0; dst = '0;
        for (int i = 0; i < TS; i++)
            if (!hit && m_v[i] && (((tag ^ m_src[i]) & m_mask[i]) == '0)) begin
                hit = 1'b1; dst = m_dst[i];
            end
        dup = 1'b0;
        for (int i = 0; i < TS; i++)
            for (int j = i + 1; j < TS; j++)
                if (m_v[i] && m_v[j] && m_src[i] == m_src[j] && m_mask[i] == m_mask[j]) dup = 1'b1;
        bad = bus.cfg_we && (int'(bus.cfg_addr) >= TS);
        if (!m_err_v) begin
            if (dup)              begin m_err_v = 1'b1; m_err_code = CFG_MAP_TAG_DUP_TAG;  end
            else if (bad)         begin m_err_v = 1'b1; m_err_code = CFG_MAP_TAG_BAD_ADDR; end
            else if (acc && !hit) begin m_err_v = 1'b1; m_err_code = RT_MAP_TAG_NO_MATCH;  end
        end
        if (pop) void'(mq.pop_front());
        if (acc && hit) mq.push_back({dst, bus.in_data[DW-1:0]});
        if (acc && hit && m_hits < 64'hFFFF_FFFF) m_hits++;
        if (acc && !hit && m_miss < 64'hFFFF_FFFF) m_miss++;
        if (bus.cfg_we && !bad) begin
            a = int'(bus.cfg_addr);
            m_v[a]    = bus.cfg_wdata[0];
            m_src[a]  = bus.cfg_wdata[1 +: ITW];
            m_mask[a] = bus.cfg_wdata[1+ITW +: ITW];
            m_dst[a]  = bus.cfg_wdata[1+2*ITW +: OTW];
        end
    endtask

    task automatic cmp();
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        chk("in_ready", 64'(bus.in_ready), 64'(mq.size() != 2));
        if (mq.size() != 0) chk("out_data", 64'(bus.out_data), 64'(mq[0]));
        chk("error_valid", 64'(error_valid), 64'(m_err_v));
        chk("error_code", 64'(error_code), 64'(m_err_code));
`ifdef FABRIC_MAP_TAG_PIPE_STATS_EN
        chk("hit_count", 64'(hit_count), m_hits);
        chk("miss_count", 64'(miss_count), m_miss);
`endif
    endtask

    // Advance one cycle: model follows the edge, outputs compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        if (!rst) cmp();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [AW-1:0] addr, input logic [EW-1:0] data);
        bus.cfg_we = 1'b1; bus.cfg_addr = addr; bus.cfg_wdata = data;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic send(input logic [ITW-1:0] tag, input logic [DW-1:0] val);
        logic r;
        int   n;
        bus.in_valid = 1'b1; bus.in_data = {tag, val};
        n = 0;
        do begin
            r = bus.in_ready;
            tick();
            n++;
        end while (!r && n < 50);
        if (!r) chk("send_timeout", 64'(r), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        model_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset values
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_err_valid", 64'(error_valid), 64'd0);
        chk("rst_err_code", 64'(error_code), 64'd0);

        // Exact map, one-cycle latency
        cfg_write(3'd0, mk(2'h1, 4'hF, 4'h3, 1'b1));
        bus.in_valid = 1'b1; bus.in_data = {4'h3, 32'hDEAD_BEEF};
        tick();
        bus.in_valid = 1'b0;
        chk("exact_out", 64'({bus.out_valid, bus.out_data}), 64'({1'b1, 2'h1, 32'hDEAD_BEEF}));
        tick();

        // Wildcard entry at lower index wins
        cfg_write(3'd0, mk(2'h2, 4'h8, 4'h8, 1'b1));
        cfg_write(3'd1, mk(2'h3, 4'hF, 4'hA, 1'b1));
        send(4'hA, 32'h1234_5678);
        chk("prio_out", 64'(bus.out_data), 64'({2'h2, 32'h1234_5678}));
        chk("prio_no_err", 64'(error_valid), 64'd0);
        tick();

        // Miss on empty table
        do_reset();
        send(4'h5, 32'h55);
        chk("miss_out_valid", 64'(bus.out_valid), 64'd0);
        chk("miss_err_valid", 64'(error_valid), 64'd1);
        chk("miss_code", 64'(error_code), 64'(RT_MAP_TAG_NO_MATCH));
        send(4'h6, 32'h66);
        tick();
        chk("miss2_code", 64'(error_code), 64'(RT_MAP_TAG_NO_MATCH));

        // Backpressure
        do_reset();
        cfg_write(3'd0, mk(2'h1, 4'h0, 4'h0, 1'b1));
        bus.out_ready = 1'b0;
        send(4'h1, 32'hA1);
        send(4'h2, 32'hA2);
        chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1; bus.in_data = {4'h3, 32'hA3};
        tick();
        tick();
        chk("bp_stall_head", 64'(bus.out_data), 64'({2'h1, 32'hA1}));
        chk("bp_stall_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_pop1", 64'(bus.out_data), 64'({2'h1, 32'hA2}));
        chk("bp_ready_after_pop", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_pop2", 64'(bus.out_data), 64'({2'h1, 32'hA3}));
        tick();
        chk("bp_drain", 64'(bus.out_valid), 64'd0);

        // Duplicate entries
        do_reset();
        cfg_write(3'd0, mk(2'h1, 4'hF, 4'h3, 1'b1));
        cfg_write(3'd2, mk(2'h1, 4'hF, 4'h3, 1'b1));
        tick();
        chk("dup_code", 64'(error_code), 64'(CFG_MAP_TAG_DUP_TAG));

        // Out-of-range write
        do_reset();
        cfg_write(3'(TS), mk(2'h1, 4'h0, 4'h0, 1'b1));
        chk("bad_addr_code", 64'(error_code), 64'(CFG_MAP_TAG_BAD_ADDR));
        send(4'h7, 32'h77);
        chk("bad_addr_table", 64'(bus.out_valid), 64'd0);
        chk("bad_addr_hold", 64'(error_code), 64'(CFG_MAP_TAG_BAD_ADDR));

        // Write and lookup in the same cycle
        do_reset();
        cfg_write(3'd0, mk(2'h1, 4'hF, 4'h3, 1'b1));
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_wdata = mk(2'h2, 4'hF, 4'h3, 1'b1);
        bus.in_valid = 1'b1; bus.in_data = {4'h3, 32'hC0};
        tick();
        bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
        chk("wr_lookup_old", 64'(bus.out_data), 64'({2'h1, 32'hC0}));
        send(4'h3, 32'hC1);
        chk("wr_lookup_new", 64'(bus.out_data), 64'({2'h2, 32'hC1}));
        tick();

`ifdef FABRIC_MAP_TAG_PIPE_STATS_EN
        do_reset();
        cfg_write(3'd0, mk(2'h1, 4'hF, 4'h3, 1'b1));
        for (int i = 0; i < 5; i++) send(4'h3, 32'(i));
        for (int i = 0; i < 2; i++) send(4'h4, 32'(i));
        tick();
        chk("stats_hits", 64'(hit_count), 64'd5);
        chk("stats_miss", 64'(miss_count), 64'd2);
`endif

        // Reset with tokens buffered
        bus.out_ready = 1'b0;
        cfg_write(3'd0, mk(2'h1, 4'h0, 4'h0, 1'b1));
        send(4'h3, 32'hE0);
        send(4'h3, 32'hE1);
        do_reset();
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef FABRIC_MAP_TAG_PIPE_STATS_EN
        chk("midrst_hits", 64'(hit_count), 64'd0);
        chk("midrst_miss", 64'(miss_count), 64'd0);
`endif
        send(4'h3, 32'hE2);
        chk("midrst_table_cleared", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;

        // Randomized traffic and table rewrites
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if (n % 200 == 199) do_reset();
            bus.cfg_we    = ($urandom_range(0, 7) == 0);
            bus.cfg_addr  = AW'($urandom_range(0, 7));
            bus.cfg_wdata = mk(OTW'($urandom),
                               ($urandom_range(0, 3) == 0) ? ITW'($urandom) : 4'hF,
                               ITW'($urandom), ($urandom_range(0, 3) != 0));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = {ITW'($urandom), DW'($urandom)};
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.cfg_we = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fabric_map_tag_pipe.md
# fabric_map_tag_pipe

Pipelined, runtime-writable tag translator for tagged fabric streams. Each accepted token's input tag is looked up in a masked CAM table, and the token is forwarded with the matched destination tag through a 2-entry output buffer. It sits on fabric links between tag domains. It replaces static-config tag mapping where the table must be rewritten while traffic runs, or where a registered timing boundary is required.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width (>= 1)
- IN_TAG_WIDTH, 4, input tag width (>= 1)
- OUT_TAG_WIDTH, 2, output tag width (>= 1)
- TABLE_SIZE, 8, number of CAM entries (>= 1)
- ENTRY_WIDTH (localparam), 1 + 2*IN_TAG_WIDTH + OUT_TAG_WIDTH; entry layout, LSB first: {dst_tag, mask, src_tag, valid}
- ADDR_WIDTH (localparam), max(1, $clog2(TABLE_SIZE))

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input token valid
- in_ready  out  1  input accepted when high together with in_valid
- in_data  in  DATA_WIDTH+IN_TAG_WIDTH  {tag, value}
- out_valid  out  1  output token valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH+OUT_TAG_WIDTH  {dst_tag, value}
- cfg_we  in  1  table write strobe
- cfg_addr  in  ADDR_WIDTH  entry index
- cfg_wdata  in  ENTRY_WIDTH  entry contents
- error_valid  out  1  sticky error flag
- error_code  out  16  first error code
- hit_count, miss_count  out  32 each  present only with FABRIC_MAP_TAG_PIPE_STATS_EN

## Operation
- Table: TABLE_SIZE registered entries, all cleared on reset (every valid = 0).
- Write: cfg_we=1 with cfg_addr < TABLE_SIZE overwrites that entry at the clock edge.
- Out-of-range write: cfg_addr >= TABLE_SIZE is ignored and raises CFG_MAP_TAG_BAD_ADDR.
- Match rule: entry i matches when valid_i and ((in_tag ^ src_tag_i) & mask_i) == 0. Mask bit 1 means compare that bit; mask 0 is a wildcard entry.
- Multiple matches: the lowest index wins. This is legal and is not an error.
- Accept: in_valid && in_ready.
- Hit: the token {dst_tag, value} is pushed into the output buffer.
- Miss: the token is consumed and discarded, nothing is pushed, and RT_MAP_TAG_NO_MATCH is raised.
- Duplicate check: CFG_MAP_TAG_DUP_TAG is raised when two valid entries have identical src_tag and identical mask. It is evaluated continuously on the registered table.
- Error latch: captures only the first error and holds it until reset.
  - Same-cycle priority: DUP_TAG > BAD_ADDR > NO_MATCH.
  - Later errors are ignored while error_valid=1.
- Errors do not block traffic.

## Timing
- Reset values: out_valid=0, in_ready=1, out_data=0, error_valid=0, error_code=0, counters=0, buffer empty.
- Latency: a token accepted in cycle N appears on out_valid in cycle N+1.
- Buffer: 2-entry FIFO; out_valid = (count != 0); out_data = head.
- in_ready = (count != 2). It is driven from registered count only, with no combinational path from out_ready.
- Full with pop: at count=2, a pop frees a slot, but in_ready stays 0 that cycle and the slot is accepted next cycle.
- Push+pop at count=1: count stays 1. The new token enters behind the head.
- Throughput: sustained 1 token/cycle while out_ready=1.
- Write/lookup in the same cycle: the lookup uses the pre-write table; the new entry applies from the next cycle.
- out_data must hold stable while out_valid && !out_ready.
- Reset mid-stream: buffered tokens are discarded and the table is cleared.

## Configuration
- FABRIC_MAP_TAG_PIPE_STATS_EN defined:
  - hit_count and miss_count ports exist.
  - Each increments on an accepted hit or miss respectively.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: the ports and counter logic are absent. All other behaviour is identical.

## Structure
- Shared fabric error package (fabric_common) holds the codes:
  - existing CFG_MAP_TAG_DUP_TAG and RT_MAP_TAG_NO_MATCH;
  - new CFG_MAP_TAG_BAD_ADDR.
- Same package also holds a parametrised helper for the entry field offsets.
- Sub-module fabric_skid_fifo2: generic 2-entry valid/ready buffer, parameter WIDTH, registered ready. Reusable by other fabric blocks.
- Elaboration-time checks: $fatal when any width or TABLE_SIZE is < 1.

## Test plan
- Exact map: write entry0 {valid=1, src=4'h3, mask=4'hF, dst=2'h1}, send value 0xDEAD_BEEF with tag 3 -> one cycle later out_data = {2'h1, 0xDEAD_BEEF}.
- Wildcard/priority: entry0 src=4'h8 mask=4'h8 dst=2, entry1 src=4'hA mask=4'hF dst=3, send tag A -> dst=2 (lowest index wins), no error.
- Miss: empty table, send tag 5 -> token consumed, out_valid stays 0, error_code=RT_MAP_TAG_NO_MATCH; a second miss leaves the code unchanged.
- Backpressure: hold out_ready=0 and stream 3 tokens -> in_ready drops after 2 accepts. Release out_ready -> tokens emerge in order, with no loss or duplication and out_data stable while stalled.
- Config hazards:
  - Write a duplicate of entry0 into entry2 -> CFG_MAP_TAG_DUP_TAG.
  - After reset, write cfg_addr=TABLE_SIZE -> CFG_MAP_TAG_BAD_ADDR, table unchanged.
  - Write entry0 in the same cycle as a tag-3 lookup -> old dst is used.
- Stats (macro on): 5 hits and 2 misses -> hit_count=5, miss_count=2. Reset mid-stream -> counters 0, out_valid 0, in_ready 1.
